// File: rtl/uart_mem_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_mem_controller_pkg
// Brief    : Command/response codes and FSM state encoding for the controller.
// Revision : 1.0
// ============================================================================
package uart_mem_controller_pkg;

  localparam logic [7:0] c_CMD_WRITE = 8'h01;
  localparam logic [7:0] c_CMD_READ  = 8'h02;
  localparam logic [7:0] c_CMD_FILL  = 8'h03;
  localparam logic [7:0] c_RESP_ACK  = 8'hAA;
  localparam logic [7:0] c_RESP_NAK  = 8'h55;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LEN       = 4'd1,
    S_ADDR      = 4'd2,
    S_WDATA     = 4'd3,
    S_FVAL      = 4'd4,
    S_FRUN      = 4'd5,
    S_RFETCH    = 4'd6,
    S_RSEND     = 4'd7,
    S_RWAIT     = 4'd8,
    S_RESP      = 4'd9,
    S_RESP_WAIT = 4'd10
  } state_t;

  function automatic logic is_command(input logic [7:0] b);
    return (b == c_CMD_WRITE) || (b == c_CMD_READ) || (b == c_CMD_FILL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_mem_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_mem_controller_if
// Brief    : UART byte-stream handshake between the UART core and controller.
// Revision : 1.0
// ============================================================================
interface uart_mem_controller_if;

  logic       received;
  logic [7:0] rx_byte;
  logic       is_transmitting;
  logic       transmit;
  logic [7:0] tx_byte;
  logic       busy;
  logic       error;

  // UART core side
  modport master (
    output received, rx_byte, is_transmitting,
    input  transmit, tx_byte, busy, error
  );

  // Controller side
  modport slave (
    input  received, rx_byte, is_transmitting,
    output transmit, tx_byte, busy, error
  );

endinterface
`default_nettype wire

// File: rtl/mc_byte_ram.sv
`default_nettype none
// ============================================================================
// Module   : mc_byte_ram
// Brief    : Byte-wide simple dual-port RAM, synchronous write, 1-cycle read.
// Revision : 1.0
// ============================================================================
module mc_byte_ram #(
  parameter int ADDR_BITS = 12
) (
  input  wire logic                 clock,
  input  wire logic                 we,
  input  wire logic [ADDR_BITS-1:0] waddr,
  input  wire logic [7:0]           wdata,
  input  wire logic [ADDR_BITS-1:0] raddr,
  output logic      [7:0]           rdata
);

  logic [7:0] r_mem [0:(1 << ADDR_BITS) - 1];

  // No reset on the array or read register so this maps onto block RAM.
  always_ff @(posedge clock) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    rdata <= r_mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/uart_mem_controller.sv
`default_nettype none
// ============================================================================
// Module   : uart_mem_controller
// Brief    : UART byte-command parser (WRITE/READ/FILL) owning a byte RAM.
// Revision : 1.0
// ============================================================================
module uart_mem_controller #(
  parameter int ADDR_BITS      = 12,
  parameter int ADDR_BYTES     = 2,
  parameter int TIMEOUT_CYCLES = 1200000
) (
  input wire logic             clock,
  input wire logic             reset_n,
  uart_mem_controller_if.slave bus
);

  import uart_mem_controller_pkg::*;

  localparam int                   c_TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]           c_ADDR_LAST  = 3'(ADDR_BYTES - 1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [7:0]             r_cmd;
  logic [7:0]             r_fill_val;
  logic [7:0]             r_resp;
  logic [8:0]             r_count;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [2:0]             r_addr_idx;
  logic [c_TIMER_W-1:0]   r_timer;
  logic                   r_hold;
  logic                   w_we;
  logic [7:0]             w_wdata;
  logic [7:0]             w_rdata;
  logic                   w_timer_run;
  logic                   w_timeout;
  logic                   w_go_nak;
  logic                   w_go_ack;

  mc_byte_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .clock (clock),
    .we    (w_we),
    .waddr (r_addr),
    .wdata (w_wdata),
    .raddr (r_addr),
    .rdata (w_rdata)
  );

  assign bus.busy = (r_state != S_IDLE);

  always_comb begin
    w_state_next = r_state;
    w_we         = 1'b0;
    w_wdata      = bus.rx_byte;
    w_go_nak     = 1'b0;
    w_go_ack     = 1'b0;
    bus.transmit = 1'b0;
    bus.tx_byte  = 8'h00;
    w_timer_run  = (r_state == S_LEN) || (r_state == S_ADDR) ||
                   (r_state == S_WDATA) || (r_state == S_FVAL);
    w_timeout    = w_timer_run && !bus.received && (r_timer == c_TIMER_LAST);

    case (r_state)
      S_IDLE: begin
        if (bus.received) begin
          if (is_command(bus.rx_byte)) w_state_next = S_LEN;
          else                         w_go_nak     = 1'b1;
        end
      end
      S_LEN: begin
        if (bus.received) w_state_next = S_ADDR;
      end
      S_ADDR: begin
        if (bus.received && (r_addr_idx == c_ADDR_LAST)) begin
          case (r_cmd)
            c_CMD_WRITE: w_state_next = S_WDATA;
            c_CMD_READ:  w_state_next = S_RFETCH;
            default:     w_state_next = S_FVAL;
          endcase
        end
      end
      S_WDATA: begin
        if (bus.received) begin
          w_we = 1'b1;
          if (r_count == 9'd1) w_go_ack = 1'b1;
        end
      end
      S_FVAL: begin
        if (bus.received) w_state_next = S_FRUN;
      end
      S_FRUN: begin
        w_we    = 1'b1;
        w_wdata = r_fill_val;
        if (r_count == 9'd1) w_go_ack = 1'b1;
      end
      S_RFETCH: begin
        // RAM output for r_addr is already valid one cycle after entry.
        if (!bus.is_transmitting) w_state_next = S_RSEND;
      end
      S_RSEND: begin
        bus.transmit = 1'b1;
        bus.tx_byte  = w_rdata;
        w_state_next = S_RWAIT;
      end
      S_RWAIT: begin
        if (r_hold && !bus.is_transmitting) begin
          w_state_next = (r_count != 9'd0) ? S_RFETCH : S_IDLE;
        end
      end
      S_RESP: begin
        if (!bus.is_transmitting) begin
          bus.transmit = 1'b1;
          bus.tx_byte  = r_resp;
          w_state_next = S_RESP_WAIT;
        end
      end
      S_RESP_WAIT: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    if (w_timeout) w_go_nak = 1'b1;
    if (w_go_nak || w_go_ack) w_state_next = S_RESP;
    bus.error = w_go_nak;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cmd      <= 8'h00;
      r_fill_val <= 8'h00;
      r_resp     <= 8'h00;
      r_count    <= 9'd0;
      r_addr     <= '0;
      r_addr_idx <= 3'd0;
      r_timer    <= '0;
      r_hold     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_hold  <= (r_state == S_RWAIT) && (w_state_next == S_RWAIT);

      if (w_timer_run && !bus.received) r_timer <= r_timer + c_TIMER_W'(1);
      else                              r_timer <= '0;

      if (w_go_nak)      r_resp <= c_RESP_NAK;
      else if (w_go_ack) r_resp <= c_RESP_ACK;

      case (r_state)
        S_IDLE: begin
          if (bus.received) begin
            r_cmd      <= bus.rx_byte;
            r_addr     <= '0;
            r_addr_idx <= 3'd0;
          end
        end
        S_LEN: begin
          if (bus.received) r_count <= {1'b0, bus.rx_byte} + 9'd1;
        end
        S_ADDR: begin
          // Shifting into an ADDR_BITS register keeps only the low bits of
          // the big-endian address; excess high bytes fall off the top.
          if (bus.received) begin
            r_addr     <= ADDR_BITS'({r_addr, bus.rx_byte});
            r_addr_idx <= r_addr_idx + 3'd1;
          end
        end
        S_WDATA: begin
          if (bus.received) begin
            r_addr  <= r_addr + ADDR_BITS'(1);
            r_count <= r_count - 9'd1;
          end
        end
        S_FVAL: begin
          if (bus.received) r_fill_val <= bus.rx_byte;
        end
        S_FRUN, S_RSEND: begin
          r_addr  <= r_addr + ADDR_BITS'(1);
          r_count <= r_count - 9'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_mem_controller
// Brief    : Randomised self-checking bench against a byte-array/queue model.
// Revision : 1.0
// ============================================================================
module tb_uart_mem_controller;

  localparam int ADDR_BITS = 12;
  localparam int DEPTH     = 1 << ADDR_BITS;

  logic clock;
  logic reset_n;
  uart_mem_controller_if bus();

  uart_mem_controller #(
    .ADDR_BITS      (ADDR_BITS),
    .ADDR_BYTES     (2),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int         n_compared   = 0;
  int         n_mismatched = 0;
  int         err_seen     = 0;
  int         exp_err      = 0;
  int         busy_fixed   = -1;
  logic [7:0] ref_mem [DEPTH];
  logic [7:0] exp_q[$];
  logic [7:0] wq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Transmit monitor: byte order, busy overlap, back-to-back strobes, errors.
  initial begin : monitor
    logic prev_tx;
    logic [8:0] exp;
    prev_tx = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.error) err_seen++;
      if (bus.transmit) begin
        check("tx_while_busy", {31'd0, bus.is_transmitting}, 32'd0);
        check("tx_back_to_back", {31'd0, prev_tx}, 32'd0);
        if (exp_q.size() > 0) exp = {1'b0, exp_q.pop_front()};
        else                  exp = 9'h1FF;
        check("tx_byte", {24'd0, bus.tx_byte}, {23'd0, exp});
      end
      prev_tx = bus.transmit;
    end
  end

  // UART transmitter model: goes busy the cycle after each strobe.
  initial begin : uart_model
    int n;
    bus.is_transmitting = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.transmit) begin
        n = (busy_fixed >= 0) ? busy_fixed : int'($urandom_range(0, 6));
        @(posedge clock); #1;
        bus.is_transmitting = (n > 0);
        repeat (n) @(posedge clock);
        #1 bus.is_transmitting = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock); #1;
    bus.received = 1'b1;
    bus.rx_byte  = b;
    @(posedge clock); #1;
    bus.received = 1'b0;
    repeat ($urandom_range(0, 3)) @(posedge clock);
  endtask

  task automatic send_header(input logic [7:0] cmd, input logic [7:0] len, input logic [15:0] addr);
    send_byte(cmd);
    send_byte(len);
    send_byte(addr[15:8]);
    send_byte(addr[7:0]);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((bus.busy || exp_q.size() != 0 || bus.is_transmitting) && n < 4000);
    check({tag, ":busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, ":pending"}, exp_q.size(), 32'd0);
    check({tag, ":errors"}, err_seen, exp_err);
  endtask

  // WRITE using the bytes in wq (LEN = wq.size()-1).
  task automatic do_write(input logic [15:0] addr);
    logic [7:0] len;
    len = 8'(wq.size() - 1);
    for (int i = 0; i < wq.size(); i++) ref_mem[(int'(addr) + i) % DEPTH] = wq[i];
    exp_q.push_back(8'hAA);
    send_header(8'h01, len, addr);
    for (int i = 0; i < wq.size(); i++) send_byte(wq[i]);
    wait_idle("write");
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [7:0] len);
    for (int i = 0; i <= int'(len); i++) exp_q.push_back(ref_mem[(int'(addr) + i) % DEPTH]);
    send_header(8'h02, len, addr);
    wait_idle("read");
  endtask

  task automatic do_fill(input logic [15:0] addr, input logic [7:0] len, input logic [7:0] val);
    for (int i = 0; i <= int'(len); i++) ref_mem[(int'(addr) + i) % DEPTH] = val;
    exp_q.push_back(8'hAA);
    send_header(8'h03, len, addr);
    send_byte(val);
    wait_idle("fill");
  endtask

  task automatic do_bad(input logic [7:0] b);
    exp_q.push_back(8'h55);
    exp_err++;
    send_byte(b);
    wait_idle("bad_cmd");
  endtask

  initial begin : main
    logic [7:0]  b;
    logic [15:0] a;
    int          sel;
    int          n;
    reset_n      = 1'b0;
    bus.received = 1'b0;
    bus.rx_byte  = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset:transmit", {31'd0, bus.transmit}, 32'd0);
    check("reset:tx_byte", {24'd0, bus.tx_byte}, 32'd0);
    check("reset:busy", {31'd0, bus.busy}, 32'd0);
    check("reset:error", {31'd0, bus.error}, 32'd0);
    @(posedge clock); #1 reset_n = 1'b1;

    // Give every RAM location a known value with maximum-length fills.
    for (int k = 0; k < DEPTH / 256; k++) do_fill(16'(k * 256), 8'hFF, 8'($urandom));

    wq = '{8'h42, 8'h43, 8'h44};
    do_write(16'h0ECD);
    busy_fixed = 5;
    do_read(16'h0ECD, 8'd2);
    busy_fixed = -1;

    wq = '{8'h11, 8'h22};
    do_write(16'h0FFF);
    do_read(16'h0FFF, 8'd1);
    do_read(16'h0000, 8'd0);
    wq = '{8'h33, 8'h44};
    do_write(16'hFFFF);
    do_read(16'h0FFF, 8'd1);

    do_fill(16'h0100, 8'd3, 8'h5A);
    do_read(16'h0100, 8'd3);

    do_bad(8'h7E);
    do_read(16'h0ECD, 8'd2);

    // Inter-byte timeout with no data, then with one byte already stored.
    exp_q.push_back(8'h55);
    exp_err++;
    send_header(8'h01, 8'd2, 16'h0300);
    wait_idle("timeout_nodata");
    exp_q.push_back(8'h55);
    exp_err++;
    ref_mem[16'h0300] = 8'h77;
    send_header(8'h01, 8'd3, 16'h0300);
    send_byte(8'h77);
    wait_idle("timeout_partial");
    do_read(16'h0300, 8'd1);

    do_read(16'hFF80, 8'hFF);

    for (int k = 0; k < 40; k++) begin
      sel = int'($urandom_range(0, 9));
      a   = 16'($urandom);
      if (sel <= 2) begin
        wq.delete();
        n = int'($urandom_range(1, 16));
        for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
        do_write(a);
      end else if (sel <= 6) begin
        do_read(a, 8'($urandom_range(0, 15)));
      end else if (sel <= 8) begin
        do_fill(a, 8'($urandom_range(0, 31)), 8'($urandom));
      end else begin
        do begin
          b = 8'($urandom);
        end while (b == 8'h01 || b == 8'h02 || b == 8'h03);
        do_bad(b);
      end
    end

    // Reset in the middle of a READ stream aborts without a response.
    for (int i = 0; i <= 20; i++) exp_q.push_back(ref_mem[(16'h0400 + i) % DEPTH]);
    send_header(8'h02, 8'd20, 16'h0400);
    n = 0;
    while (exp_q.size() > 18 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check("reset_mid:stream_started", {31'd0, exp_q.size() <= 18}, 32'd1);
    @(posedge clock); #1 reset_n = 1'b0;
    @(posedge clock); #1 exp_q.delete();
    repeat (3) begin
      @(negedge clock);
      check("reset_mid:transmit", {31'd0, bus.transmit}, 32'd0);
      check("reset_mid:busy", {31'd0, bus.busy}, 32'd0);
    end
    @(posedge clock); #1 reset_n = 1'b1;
    wait_idle("after_reset");
    do_read(16'h0ECD, 8'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire
